// File: rtl/decode_ctrl_pipe.sv
// decode_ctrl_pipe
//   Main decoder for the five-stage MIPS core, with a registered D/E control
//   stage and a multi-cycle divide sequencer.
//
//   Parameters
//     DIV_CYCLES : divider busy cycles (>= 2)
//     LINK_REG   : link destination register, used by the register-file
//                  write mux; only range-checked here
//
//   Ports
//     clk, resetn            : rising-edge clock, asynchronous active-low reset
//     instrD, validD         : D-stage instruction and its valid flag
//     stallE, flushE         : hold / bubble the E control register (flush wins)
//     branchD, jumpD, jrD    : combinational D-stage control-flow decisions
//     memtoregE .. riE       : registered E-stage controls
//     div_start              : one-cycle divider launch pulse
//     div_stall              : freeze F, D and E while the divider runs
module decode_ctrl_pipe #(
  parameter int DIV_CYCLES = 32,
  parameter int LINK_REG   = 31
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] instrD,
  input  logic        validD,
  input  logic        stallE,
  input  logic        flushE,
  output logic        branchD,
  output logic        jumpD,
  output logic        jrD,
  output logic        memtoregE,
  output logic        memwriteE,
  output logic        alusrcE,
  output logic        regdstE,
  output logic        regwriteE,
  output logic        linkE,
  output logic [1:0]  hregwriteE,
  output logic [1:0]  memsizeE,
  output logic        memsignE,
  output logic        riE,
  output logic        div_start,
  output logic        div_stall
);

  if (DIV_CYCLES < 2 || LINK_REG < 0 || LINK_REG > 31) begin : g_bad_param
    $error("decode_ctrl_pipe: DIV_CYCLES must be >= 2 and LINK_REG within 0..31");
  end

  localparam int CNT_W = $clog2(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DIV_CYCLES - 1);

  typedef struct packed {
    logic       memtoreg;
    logic       memwrite;
    logic       alusrc;
    logic       regdst;
    logic       regwrite;
    logic       link;
    logic [1:0] hregwrite;
    logic [1:0] memsize;
    logic       memsign;
    logic       ri;
    logic       div;
  } ctrl_t;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rt;
  logic       branch_c;
  logic       jump_c;
  logic       jr_c;
  ctrl_t      ctrl_d;
  ctrl_t      ctrl_q;
  state_t     state_d;
  state_t     state_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  // rs, rd, shamt and the immediate carry no control information.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instrD[25:21], instrD[15:6]};

  assign op    = instrD[31:26];
  assign rt    = instrD[20:16];
  assign funct = instrD[5:0];

  // ---------------- D stage: combinational decode ----------------
  always_comb begin
    ctrl_d   = '0;
    branch_c = 1'b0;
    jump_c   = 1'b0;
    jr_c     = 1'b0;
    if (validD) begin
      case (op)
        6'h00: begin
          ctrl_d.regdst   = 1'b1;
          ctrl_d.regwrite = 1'b1;
          case (funct)
            6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
            6'h10, 6'h12,
            6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
            6'h2A, 6'h2B: ;
            6'h08: begin
              ctrl_d.regwrite = 1'b0;
              jr_c            = 1'b1;
            end
            6'h09: begin
              jr_c        = 1'b1;
              ctrl_d.link = 1'b1;
            end
            6'h11: begin
              ctrl_d.regwrite  = 1'b0;
              ctrl_d.hregwrite = 2'b10;
            end
            6'h13: begin
              ctrl_d.regwrite  = 1'b0;
              ctrl_d.hregwrite = 2'b01;
            end
            6'h18, 6'h19: begin
              ctrl_d.regwrite  = 1'b0;
              ctrl_d.hregwrite = 2'b11;
            end
            6'h1A, 6'h1B: begin
              ctrl_d.regwrite  = 1'b0;
              ctrl_d.hregwrite = 2'b11;
              ctrl_d.div       = 1'b1;
            end
            default: begin
              ctrl_d    = '0;
              ctrl_d.ri = 1'b1;
            end
          endcase
        end
        6'h01: begin
          case (rt)
            5'd0, 5'd1: branch_c = 1'b1;
            5'd16, 5'd17: begin
              branch_c        = 1'b1;
              ctrl_d.regwrite = 1'b1;
              ctrl_d.link     = 1'b1;
            end
            default: ctrl_d.ri = 1'b1;
          endcase
        end
        6'h02: jump_c = 1'b1;
        6'h03: begin
          jump_c          = 1'b1;
          ctrl_d.regwrite = 1'b1;
          ctrl_d.link     = 1'b1;
        end
        6'h04, 6'h05, 6'h06, 6'h07: branch_c = 1'b1;
        6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
          ctrl_d.alusrc   = 1'b1;
          ctrl_d.regwrite = 1'b1;
        end
        6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
          ctrl_d.alusrc   = 1'b1;
          ctrl_d.memtoreg = 1'b1;
          ctrl_d.regwrite = 1'b1;
          case (op)
            6'h20:   begin ctrl_d.memsize = 2'b00; ctrl_d.memsign = 1'b1; end
            6'h21:   begin ctrl_d.memsize = 2'b01; ctrl_d.memsign = 1'b1; end
            6'h24:   ctrl_d.memsize = 2'b00;
            6'h25:   ctrl_d.memsize = 2'b01;
            default: ctrl_d.memsize = 2'b10;
          endcase
        end
        6'h28, 6'h29, 6'h2B: begin
          ctrl_d.alusrc   = 1'b1;
          ctrl_d.memwrite = 1'b1;
          case (op)
            6'h28:   ctrl_d.memsize = 2'b00;
            6'h29:   ctrl_d.memsize = 2'b01;
            default: ctrl_d.memsize = 2'b10;
          endcase
        end
        default: ctrl_d.ri = 1'b1;
      endcase
    end
  end

  assign branchD = branch_c;
  assign jumpD   = jump_c;
  assign jrD     = jr_c;

  // ---------------- D/E boundary: control register ----------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ctrl_q <= '0;
    end else if (flushE) begin
      ctrl_q <= '0;
    end else if (!stallE) begin
      ctrl_q <= ctrl_d;
    end
  end

  assign memtoregE  = ctrl_q.memtoreg;
  assign memwriteE  = ctrl_q.memwrite;
  assign alusrcE    = ctrl_q.alusrc;
  assign regdstE    = ctrl_q.regdst;
  assign regwriteE  = ctrl_q.regwrite;
  assign linkE      = ctrl_q.link;
  assign hregwriteE = ctrl_q.hregwrite;
  assign memsizeE   = ctrl_q.memsize;
  assign memsignE   = ctrl_q.memsign;
  assign riE        = ctrl_q.ri;

  // ---------------- E stage: divide sequencer ----------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flushE) begin
      // The divide in E is being discarded, so abandon the sequence too.
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ctrl_q.div) begin
            state_d = S_BUSY;
            cnt_d   = CNT_INIT;
          end
        end
        S_BUSY: begin
          if (cnt_q == '0) begin
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_DONE: begin
          // Leave only once E advances, otherwise the same divide would relaunch.
          if (!stallE) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    div_start = (state_q == S_IDLE) && ctrl_q.div;
    div_stall = ctrl_q.div && (state_q != S_DONE);
  end

endmodule

// File: doc/decode_ctrl_pipe.md
# decode_ctrl_pipe

Registered successor to the decode-stage main decoder for the five-stage MIPS core. It decodes `instrD` into the control bundle and forwards branch, jump and jr decisions to the D stage combinationally. The remaining controls go into an internal D/E control register with hold and flush, so no control is ever latched while stalled. It also owns a multi-cycle divide sequencer that generates the pipeline stall for DIV/DIVU and decodes the full branch family and the reserved-instruction flag.

## Interface
- `DIV_CYCLES`, default 32: divider busy cycles, ≥2.
- `LINK_REG`, default 31: destination register for BLTZAL, BGEZAL and JAL.
- `clk` in 1: clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `instrD` in 32: D-stage instruction.
- `validD` in 1: D-stage slot holds a real instruction.
- `stallE` in 1: hold the E control register.
- `flushE` in 1: load a bubble into E; takes priority over `stallE`.
- `branchD` out 1: conditional branch in D. Combinational.
- `jumpD` out 1: J or JAL in D. Combinational.
- `jrD` out 1: JR or JALR in D. Combinational.
- `memtoregE`, `memwriteE`, `alusrcE`, `regdstE`, `regwriteE`, `linkE` out 1 each: registered controls.
- `hregwriteE` out 2: HI/LO write enables, bit1 = HI and bit0 = LO.
- `memsizeE` out 2: 00 = byte, 01 = half, 10 = word.
- `memsignE` out 1: sign-extend the load.
- `riE` out 1: reserved or unknown instruction.
- `div_start` out 1: one-cycle pulse that launches the divider.
- `div_stall` out 1: freeze F, D and E.

## Operation
- **Decode (combinational, gated by `validD`):**
  - Zero all controls when `validD` = 0.
  - SPECIAL (op 0):
    - `regdst` = 1.
    - `regwrite` = 1 except for MULT, MULTU, DIV, DIVU, MTHI, MTLO and JR.
    - `hregwrite` = 11 for MULT, MULTU, DIV and DIVU; 10 for MTHI; 01 for MTLO.
    - `jr` = 1 for JR and JALR.
    - JALR sets `link`.
    - Any unlisted funct sets `ri`.
  - I-type ALU ops (ADDI, ADDIU, SLTI, SLTIU, ANDI, ORI, XORI, LUI): `alusrc` = 1 and `regwrite` = 1.
  - Loads:
    - `alusrc`, `memtoreg` and `regwrite` = 1.
    - LB and LBU use size 00; LH and LHU use 01; LW uses 10.
    - `memsign` = 1 for LB and LH.
  - Stores (SB, SH, SW): `alusrc` = 1 and `memwrite` = 1, with size set the same way as loads.
  - `branch` = 1 for BEQ, BNE, BGTZ, BLEZ and REGIMM (op 1) with rt ∈ {0, 1, 16, 17}.
    - BLTZAL and BGEZAL also set `regwrite` and `link`.
    - Any other rt sets `ri`.
  - `jump` = 1 for J and JAL. JAL also sets `regwrite` and `link`.
  - Any unlisted op sets `ri`, with all other controls 0.
- **E register:**
  - On each rising edge, apply the first matching case: `flushE` loads all zeros; otherwise `stallE` holds the current value; otherwise the register loads the decode result.
  - `divE` is internal: E holds DIV or DIVU.
- **Divide FSM:**
  - IDLE to BUSY when `divE`. `div_start` = 1 during that cycle and the counter loads `DIV_CYCLES`−1.
  - BUSY decrements the counter each cycle and moves to DONE when the counter reaches 0.
  - DONE returns to IDLE on the first cycle with `stallE` = 0, because E then advances.
  - `div_stall` = `divE` AND state ≠ DONE.
  - `flushE` while in BUSY or DONE returns the FSM to IDLE next cycle, and `div_start` is not re-issued for the flushed divide.

## Timing
- **Reset** (`resetn` low, asynchronous): all E outputs are 0, the FSM is in IDLE, the counter is 0, and `div_start` and `div_stall` are 0.
  - Releasing reset mid-divide leaves nothing pending.
- **D-stage outputs** are zero-latency combinational from `instrD` and `validD`.
- **E outputs** are valid one edge after the instruction sits in D with `stallE` = 0.
- **Divide timing:**
  - `div_stall` is high for exactly `DIV_CYCLES`+1 cycles, counted from the first cycle `divE` is seen.
  - `div_start` is high only in the first of those cycles.
  - `div_stall` is low in DONE.
- **Back-to-back divides:** a second DIV entering E on the edge that leaves DONE gets a fresh `div_start` in its first cycle.
- **Simultaneous events:**
  - When `flushE` and `stallE` are both high, the flush wins.
  - When `validD` = 0, a bubble is loaded, never a stale hold.

## Test plan
- **Reset:** hold `resetn` low with `instrD` = LW. Required: all E outputs 0 and `div_stall` = 0. After release and one edge: `memtoregE` = 1, `memsizeE` = 10, `regwriteE` = 1, `alusrcE` = 1.
- **Decode sweep:**
  - LB gives `memsignE` = 1.
  - LHU gives size 01 with `memsignE` = 0.
  - SB gives `memwriteE` = 1 and size 00.
  - MTHI gives `hregwriteE` = 10 and `regwriteE` = 0.
  - BGEZAL (op 1, rt 17) gives `branchD` = 1 and `linkE` = 1.
  - op 0x3F gives `riE` = 1.
- **Stall and flush:**
  - Load ORI, then assert `stallE` for 3 cycles while `instrD` changes to SW. Required: `alusrcE` = 1 and `memwriteE` = 0 throughout.
  - Assert `flushE` and `stallE` together. Required: all E outputs are 0 next cycle.
- **Divide, `DIV_CYCLES` = 4:**
  - DIV enters E. Required: `div_start` pulses in cycle 0, `div_stall` is high in cycles 0–4, low in cycle 5, and `hregwriteE` = 11.
  - Repeat with a second DIV directly behind it. Required: a second start pulse and a 5-cycle stall.
- **Divide abort:** `flushE` in cycle 2 of a divide. Required: `div_stall` is 0 next cycle, the FSM is in IDLE, and no `div_start` follows.
- **Reset mid-divide:** drop `resetn` in cycle 3 of a divide. Required: `div_stall` falls immediately (asynchronously) and stays 0 after release with NOP in D.
